// File: rtl/rcpu_io_pkg.sv
// Shared constants and types for the RCPU I/O UART transmitter.
package rcpu_io_pkg;

  // Register offsets from the block's base address.
  localparam logic [15:0] REG_DATA   = 16'd0;
  localparam logic [15:0] REG_STATUS = 16'd1;
  localparam logic [15:0] REG_DIV    = 16'd2;

  // STATUS register bit positions (count occupies bits [8:4]).
  localparam int STAT_BUSY  = 0;
  localparam int STAT_FULL  = 1;
  localparam int STAT_EMPTY = 2;
  localparam int STAT_OVF   = 3;
  localparam int STAT_COUNT = 4;

  // Serialiser states.
  typedef enum logic [1:0] {
    SER_IDLE  = 2'd0,
    SER_START = 2'd1,
    SER_DATA  = 2'd2,
    SER_STOP  = 2'd3
  } ser_state_t;

  // Assemble the STATUS word from its fields, zero-extended to 16 bits.
  function automatic logic [15:0] status_word(
    input logic [4:0] count,
    input logic       ovf,
    input logic       empty,
    input logic       full,
    input logic       busy
  );
    logic [15:0] w;
    w                     = '0;
    w[STAT_COUNT +: 5]    = count;
    w[STAT_OVF]           = ovf;
    w[STAT_EMPTY]         = empty;
    w[STAT_FULL]          = full;
    w[STAT_BUSY]          = busy;
    return w;
  endfunction

endpackage

// File: rtl/rcpu_io_fifo.sv
// Small synchronous FIFO with combinational read of the head entry.
// A push while full is accepted only when a pop happens at the same edge.
module rcpu_io_fifo #(
  parameter  int WIDTH = 8,
  parameter  int DEPTH = 4,
  localparam int AW    = $clog2(DEPTH),
  localparam int CW    = AW + 1
) (
  input  logic             clk,
  input  logic             resetq,
  input  logic             push,
  input  logic             pop,
  input  logic [WIDTH-1:0] wdata,
  output logic [WIDTH-1:0] rdata,
  output logic             full,
  output logic             empty,
  output logic [CW-1:0]    count
);

  logic [WIDTH-1:0] mem [DEPTH];
  logic [AW-1:0]    wr_ptr;
  logic [AW-1:0]    rd_ptr;
  logic             do_push;
  logic             do_pop;

  assign do_pop  = pop && !empty;
  assign do_push = push && (!full || do_pop);

  assign full  = (count == CW'(DEPTH));
  assign empty = (count == '0);
  assign rdata = mem[rd_ptr];

  // Storage array; contents need no reset because the pointers define validity.
  always_ff @(posedge clk) begin
    if (do_push) begin
      mem[wr_ptr] <= wdata;
    end
  end

  // Pointers and occupancy count; depth is a power of two so pointers wrap freely.
  always_ff @(posedge clk) begin
    if (!resetq) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (do_push) begin
        wr_ptr <= wr_ptr + AW'(1);
      end
      if (do_pop) begin
        rd_ptr <= rd_ptr + AW'(1);
      end
      case ({do_push, do_pop})
        2'b10:   count <= count + CW'(1);
        2'b01:   count <= count - CW'(1);
        default: count <= count;
      endcase
    end
  end

endmodule

// File: rtl/rcpu_io_uart_tx.sv
// Memory-mapped 8N1 UART transmitter on the j1 I/O bus.
// Bus handshake: io_read_enable / io_write_enable are single-cycle strobes
// with no back-pressure; a read strobe at edge N yields io_read_data after
// edge N, held until the next read. Read and write in the same cycle are
// serviced independently.
module rcpu_io_uart_tx
  import rcpu_io_pkg::*;
#(
  parameter logic [15:0] BASE_ADDR   = 16'h0010,
  parameter logic [15:0] DEFAULT_DIV = 16'd434,
  parameter int          FIFO_DEPTH  = 4   // power of two, 2..16
) (
  input  logic        clk,
  input  logic        resetq,
  input  logic        io_read_enable,
  input  logic        io_write_enable,
  input  logic [0:15] io_addr,
  input  logic [0:15] io_write_data,
  output logic [0:15] io_read_data,
  output logic        uart_tx,
  output logic        tx_idle,
  output ser_state_t  dbg_state
);

  localparam int CW = $clog2(FIFO_DEPTH) + 1;

  // Bus decode
  logic [15:0] wdata_w;
  logic        sel_data;
  logic        sel_status;
  logic        sel_div;
  logic        wr_data;
  logic        wr_div;
  logic        rd_status;

  assign wdata_w    = io_write_data;
  assign sel_data   = (io_addr == BASE_ADDR + REG_DATA);
  assign sel_status = (io_addr == BASE_ADDR + REG_STATUS);
  assign sel_div    = (io_addr == BASE_ADDR + REG_DIV);
  assign wr_data    = io_write_enable && sel_data;
  assign wr_div     = io_write_enable && sel_div;
  assign rd_status  = io_read_enable && sel_status;

  // FIFO
  logic          fifo_pop;
  logic [7:0]    fifo_rdata;
  logic          fifo_full;
  logic          fifo_empty;
  logic [CW-1:0] fifo_count;

  rcpu_io_fifo #(
    .WIDTH (8),
    .DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .clk    (clk),
    .resetq (resetq),
    .push   (wr_data),
    .pop    (fifo_pop),
    .wdata  (wdata_w[7:0]),
    .rdata  (fifo_rdata),
    .full   (fifo_full),
    .empty  (fifo_empty),
    .count  (fifo_count)
  );

  // Registers
  logic [15:0] div_q;
  logic        overflow_q;
  logic        overflow_set;
  logic        busy;
  logic [15:0] rd_mux;

  // A push into a full FIFO is lost unless a pop frees the slot at the same edge.
  assign overflow_set = wr_data && fifo_full && !fifo_pop;

  // Divisor register; zero would stall the bit timer, so it is stored as 1.
  always_ff @(posedge clk) begin
    if (!resetq) begin
      div_q <= DEFAULT_DIV;
    end else if (wr_div) begin
      div_q <= (wdata_w == 16'd0) ? 16'd1 : wdata_w;
    end
  end

  // Sticky overflow flag: set wins over the clear-on-read of STATUS.
  always_ff @(posedge clk) begin
    if (!resetq) begin
      overflow_q <= 1'b0;
    end else if (overflow_set) begin
      overflow_q <= 1'b1;
    end else if (rd_status) begin
      overflow_q <= 1'b0;
    end
  end

  // Read mux; unmapped and DATA addresses read as zero for OR-combining.
  always_comb begin
    rd_mux = '0;
    if (sel_status) begin
      rd_mux = status_word(5'(fifo_count), overflow_q, fifo_empty, fifo_full, busy);
    end else if (sel_div) begin
      rd_mux = div_q;
    end
  end

  // Registered read data, held between reads.
  always_ff @(posedge clk) begin
    if (!resetq) begin
      io_read_data <= '0;
    end else if (io_read_enable) begin
      io_read_data <= rd_mux;
    end
  end

  // Serialiser
  ser_state_t  state_q;
  ser_state_t  state_d;
  logic [15:0] bit_cnt_q;
  logic [15:0] frame_div_q;
  logic [2:0]  bit_idx_q;
  logic [7:0]  shift_q;
  logic [7:0]  shift_d;
  logic        bit_end;
  logic        tx_d;

  assign bit_end   = (bit_cnt_q == 16'd0);
  assign tx_idle   = fifo_empty && (state_q == SER_IDLE);
  assign busy      = !tx_idle;
  assign dbg_state = state_q;

  // FSM state register.
  always_ff @(posedge clk) begin
    if (!resetq) begin
      state_q <= SER_IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // FSM next-state logic; STOP chains straight into START when data is waiting.
  always_comb begin
    state_d = state_q;
    case (state_q)
      SER_IDLE:  if (!fifo_empty) state_d = SER_START;
      SER_START: if (bit_end) state_d = SER_DATA;
      SER_DATA:  if (bit_end && (bit_idx_q == 3'd7)) state_d = SER_STOP;
      SER_STOP:  if (bit_end) state_d = fifo_empty ? SER_IDLE : SER_START;
      default:   state_d = SER_IDLE;
    endcase
  end

  // FSM outputs: pop at frame start, next shift value and next line level.
  always_comb begin
    fifo_pop = !fifo_empty &&
               ((state_q == SER_IDLE) || ((state_q == SER_STOP) && bit_end));
    shift_d  = shift_q;
    if (fifo_pop) begin
      shift_d = fifo_rdata;
    end else if ((state_q == SER_DATA) && bit_end) begin
      shift_d = {1'b0, shift_q[7:1]};
    end
    tx_d = 1'b1;
    case (state_d)
      SER_START: tx_d = 1'b0;
      SER_DATA:  tx_d = shift_d[0];
      default:   tx_d = 1'b1;
    endcase
  end

  // Bit timer, bit index, shifter and the registered line driver.
  // The divisor is captured per frame so DIV writes only affect later frames.
  always_ff @(posedge clk) begin
    if (!resetq) begin
      bit_cnt_q   <= '0;
      frame_div_q <= DEFAULT_DIV;
      bit_idx_q   <= '0;
      shift_q     <= '0;
      uart_tx     <= 1'b1;
    end else begin
      shift_q <= shift_d;
      uart_tx <= tx_d;
      if (fifo_pop) begin
        frame_div_q <= div_q;
        bit_cnt_q   <= div_q - 16'd1;
      end else if (state_q != SER_IDLE) begin
        if (bit_end) begin
          bit_cnt_q <= frame_div_q - 16'd1;
        end else begin
          bit_cnt_q <= bit_cnt_q - 16'd1;
        end
      end
      if (state_q == SER_START) begin
        bit_idx_q <= '0;
      end else if ((state_q == SER_DATA) && bit_end) begin
        bit_idx_q <= bit_idx_q + 3'd1;
      end
    end
  end

endmodule
